// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the i_cache and the d_cache.
// Cache-line refills are issued as BURST_LEN back-to-back word beats starting
// at the line-aligned address; each returned word is forwarded to the winning
// cache with a one-cycle valid pulse, and the final beat also pulses done.
// A d_cache write is a single word beat that only pulses o_dc_done.
// When both caches request in the same cycle, the one that did not win the
// previous arbitration is granted (two-way round robin).
//
// Ports
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_ic_req, i_ic_addr    i_cache refill request and miss address
//   o_ic_data              refill word returned to the i_cache
//   o_ic_valid, o_ic_done  per-beat valid pulse, last-beat done pulse
//   i_dc_req, i_dc_we      d_cache request; we=1 single-word write, we=0 refill
//   i_dc_addr, i_dc_wdata  d_cache address and write data
//   o_dc_data              refill word returned to the d_cache
//   o_dc_valid, o_dc_done  per-beat valid pulse, transaction-complete pulse
//   o_mem_req, o_mem_we    memory beat request / write enable
//   o_mem_addr, o_mem_wdata memory word address / write data
//   i_mem_ack, i_mem_rdata beat complete this cycle, with read data
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int XLEN      = 32,
    parameter int BURST_LEN = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ic_req,
    input  logic [XLEN-1:0] i_ic_addr,
    output logic [XLEN-1:0] o_ic_data,
    output logic            o_ic_valid,
    output logic            o_ic_done,
    input  logic            i_dc_req,
    input  logic            i_dc_we,
    input  logic [XLEN-1:0] i_dc_addr,
    input  logic [XLEN-1:0] i_dc_wdata,
    output logic [XLEN-1:0] o_dc_data,
    output logic            o_dc_valid,
    output logic            o_dc_done,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    // Clears the byte offset within a line (refills) or within a word (writes).
    localparam logic [XLEN-1:0] LINE_MASK = ~(XLEN'(BURST_LEN * 4 - 1));
    localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic {
        GNT_IC,
        GNT_DC
    } grant_t;

    // Registered state and outputs
    state_t            state_q;
    grant_t            grant_q;
    grant_t            last_grant_q;
    logic [BEAT_W-1:0] beat_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [XLEN-1:0]   ic_data_q;
    logic              ic_valid_q;
    logic              ic_done_q;
    logic [XLEN-1:0]   dc_data_q;
    logic              dc_valid_q;
    logic              dc_done_q;

    // Next-state values
    state_t            state_n;
    grant_t            grant_n;
    grant_t            last_grant_n;
    logic [BEAT_W-1:0] beat_n;
    logic              mem_req_n;
    logic              mem_we_n;
    logic [XLEN-1:0]   mem_addr_n;
    logic [XLEN-1:0]   mem_wdata_n;
    logic [XLEN-1:0]   ic_data_n;
    logic              ic_valid_n;
    logic              ic_done_n;
    logic [XLEN-1:0]   dc_data_n;
    logic              dc_valid_n;
    logic              dc_done_n;

    grant_t            winner;
    logic [XLEN-1:0]   next_beat_addr;

    // Advance the word offset while keeping the line bits fixed, so a carry
    // out of the offset field can never move the burst into the next line.
    assign next_beat_addr = (mem_addr_q & LINE_MASK)
                          | ((mem_addr_q + WORD_STEP) & ~LINE_MASK);

    // Round robin: on a tie the requester that lost last time wins.
    always_comb begin
        winner = GNT_IC;
        if (i_ic_req && i_dc_req) begin
            winner = (last_grant_q == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (i_dc_req) begin
            winner = GNT_DC;
        end
    end

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default at the top, so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_n      = state_q;
        grant_n      = grant_q;
        last_grant_n = last_grant_q;
        beat_n       = beat_q;
        mem_req_n    = mem_req_q;
        mem_we_n     = mem_we_q;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;
        ic_data_n    = ic_data_q;
        dc_data_n    = dc_data_q;
        // Valid and done are single-cycle pulses.
        ic_valid_n   = 1'b0;
        ic_done_n    = 1'b0;
        dc_valid_n   = 1'b0;
        dc_done_n    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Acks arriving here are ignored: no beat is outstanding.
                if (i_ic_req || i_dc_req) begin
                    state_n      = S_BUSY;
                    grant_n      = winner;
                    last_grant_n = winner;
                    beat_n       = '0;
                    mem_req_n    = 1'b1;
                    if (winner == GNT_IC) begin
                        mem_we_n   = 1'b0;
                        mem_addr_n = i_ic_addr & LINE_MASK;
                    end else if (i_dc_we) begin
                        mem_we_n    = 1'b1;
                        mem_addr_n  = i_dc_addr & WORD_MASK;
                        mem_wdata_n = i_dc_wdata;
                    end else begin
                        mem_we_n   = 1'b0;
                        mem_addr_n = i_dc_addr & LINE_MASK;
                    end
                end
            end

            S_BUSY: begin
                // Request, address and write data stay put until the ack.
                if (i_mem_ack) begin
                    if (mem_we_q) begin
                        // Single-word write: completion only, no data beat.
                        dc_done_n = 1'b1;
                        mem_req_n = 1'b0;
                        mem_we_n  = 1'b0;
                        state_n   = S_IDLE;
                    end else begin
                        if (grant_q == GNT_IC) begin
                            ic_data_n  = i_mem_rdata;
                            ic_valid_n = 1'b1;
                        end else begin
                            dc_data_n  = i_mem_rdata;
                            dc_valid_n = 1'b1;
                        end

                        if (beat_q == LAST_BEAT) begin
                            ic_done_n = (grant_q == GNT_IC);
                            dc_done_n = (grant_q == GNT_DC);
                            mem_req_n = 1'b0;
                            state_n   = S_IDLE;
                        end else begin
                            // Request stays high: the next beat follows
                            // with no idle cycle in between.
                            beat_n     = beat_q + BEAT_ONE;
                            mem_addr_n = next_beat_addr;
                        end
                    end
                end
            end

            default: begin
                state_n   = S_IDLE;
                mem_req_n = 1'b0;
                mem_we_n  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= GNT_IC;
            // Starting from DC makes the first contested grant go to the IC.
            last_grant_q <= GNT_DC;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ic_data_q    <= '0;
            ic_valid_q   <= 1'b0;
            ic_done_q    <= 1'b0;
            dc_data_q    <= '0;
            dc_valid_q   <= 1'b0;
            dc_done_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            grant_q      <= grant_n;
            last_grant_q <= last_grant_n;
            beat_q       <= beat_n;
            mem_req_q    <= mem_req_n;
            mem_we_q     <= mem_we_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            ic_data_q    <= ic_data_n;
            ic_valid_q   <= ic_valid_n;
            ic_done_q    <= ic_done_n;
            dc_data_q    <= dc_data_n;
            dc_valid_q   <= dc_valid_n;
            dc_done_q    <= dc_done_n;
        end
    end

    assign o_ic_data   = ic_data_q;
    assign o_ic_valid  = ic_valid_q;
    assign o_ic_done   = ic_done_q;
    assign o_dc_data   = dc_data_q;
    assign o_dc_valid  = dc_valid_q;
    assign o_dc_done   = dc_done_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. Each test pushes the memory beats it expects, in the
// order they should be served, onto a scoreboard queue. A memory responder
// compares every cycle of an outstanding request against the queue head, acks
// according to a per-test ack pattern, and on ack moves the beat to a pending
// slot; the following cycle the cache-side outputs must show exactly that
// beat's valid/done pulse and data. Requesters drop their request on done.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int BL   = 4;

    typedef struct {
        logic            is_ic;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            last;
    } beat_t;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_ic_req;
    logic [XLEN-1:0] i_ic_addr;
    logic [XLEN-1:0] o_ic_data;
    logic            o_ic_valid;
    logic            o_ic_done;
    logic            i_dc_req;
    logic            i_dc_we;
    logic [XLEN-1:0] i_dc_addr;
    logic [XLEN-1:0] i_dc_wdata;
    logic [XLEN-1:0] o_dc_data;
    logic            o_dc_valid;
    logic            o_dc_done;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic            i_mem_ack;
    logic [XLEN-1:0] i_mem_rdata;

    mem_arbiter #(
        .XLEN      (XLEN),
        .BURST_LEN (BL)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ic_req    (i_ic_req),
        .i_ic_addr   (i_ic_addr),
        .o_ic_data   (o_ic_data),
        .o_ic_valid  (o_ic_valid),
        .o_ic_done   (o_ic_done),
        .i_dc_req    (i_dc_req),
        .i_dc_we     (i_dc_we),
        .i_dc_addr   (i_dc_addr),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_data   (o_dc_data),
        .o_dc_valid  (o_dc_valid),
        .o_dc_done   (o_dc_done),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    beat_t exp_q[$];
    bit    ack_q[$];
    beat_t resp_exp;
    bit    resp_pend    = 1'b0;
    bit    hold_ic      = 1'b0;
    bit    idle_ack     = 1'b0;
    int    ic_valid_cnt = 0;
    int    ic_done_cnt  = 0;
    int    ic_done_cyc  = 0;
    int    dc_done_cyc  = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Number of rising edges so far; read on falling edges.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory contents model: distinct word per address.
    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic push_refill(input logic is_ic, input logic [XLEN-1:0] addr);
        beat_t b;
        for (int i = 0; i < BL; i++) begin
            b.is_ic = is_ic;
            b.we    = 1'b0;
            b.addr  = (addr & ~32'(BL * 4 - 1)) + 32'(4 * i);
            b.wdata = '0;
            b.last  = (i == BL - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_write(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata);
        beat_t b;
        b.is_ic = 1'b0;
        b.we    = 1'b1;
        b.addr  = addr & ~32'h3;
        b.wdata = wdata;
        b.last  = 1'b1;
        exp_q.push_back(b);
    endtask

    // Ack pattern, first cycle in the MSB of the n used bits.
    task automatic set_acks(input logic [15:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) ack_q.push_back(pat[i]);
    endtask

    task automatic flush();
        exp_q.delete();
        ack_q.delete();
        resp_pend = 1'b0;
    endtask

    function automatic bit busy();
        return (exp_q.size() != 0) || resp_pend || i_ic_req || i_dc_req || (o_mem_req === 1'b1);
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (n < max_cyc && busy());
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL %s timeout: still busy after %0d cycles, %0d beats left", name, n, exp_q.size());
            flush();
            i_ic_req = 1'b0;
            i_dc_req = 1'b0;
        end
    endtask

    // Memory responder and cache-side monitor, evaluated on falling edges.
    initial begin : monitor
        beat_t      b;
        logic [3:0] got_flags;
        logic [3:0] exp_flags;
        bit         ack;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                i_mem_ack = 1'b0;
            end else begin
                got_flags = {o_ic_valid, o_ic_done, o_dc_valid, o_dc_done};
                if (o_ic_valid === 1'b1) ic_valid_cnt++;
                if (o_ic_done === 1'b1) begin
                    ic_done_cnt++;
                    ic_done_cyc = cyc;
                end
                if (o_dc_done === 1'b1) dc_done_cyc = cyc;

                checks++;
                if (resp_pend) begin
                    if (resp_exp.we)         exp_flags = 4'b0001;
                    else if (resp_exp.is_ic) exp_flags = {1'b1, resp_exp.last, 2'b00};
                    else                     exp_flags = {2'b00, 1'b1, resp_exp.last};
                    if (got_flags !== exp_flags)
                        $display("FAIL resp_flags addr %h: got {icv,icd,dcv,dcd}=%b expected %b",
                                 resp_exp.addr, got_flags, exp_flags);
                    if (got_flags !== exp_flags) errors++;
                    else if (!resp_exp.we && resp_exp.is_ic && o_ic_data !== mem_word(resp_exp.addr)) begin
                        errors++;
                        $display("FAIL ic_data addr %h: got %h expected %h",
                                 resp_exp.addr, o_ic_data, mem_word(resp_exp.addr));
                    end else if (!resp_exp.we && !resp_exp.is_ic && o_dc_data !== mem_word(resp_exp.addr)) begin
                        errors++;
                        $display("FAIL dc_data addr %h: got %h expected %h",
                                 resp_exp.addr, o_dc_data, mem_word(resp_exp.addr));
                    end
                    resp_pend = 1'b0;
                end else if (got_flags !== 4'b0000) begin
                    errors++;
                    $display("FAIL spurious_pulse: got {icv,icd,dcv,dcd}=%b expected 0000", got_flags);
                end

                if (o_ic_done === 1'b1 && !hold_ic) i_ic_req = 1'b0;
                if (o_dc_done === 1'b1) begin
                    i_dc_req = 1'b0;
                    i_dc_we  = 1'b0;
                end

                if (o_mem_req === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_mem_req: got addr %h we %b, expected no request",
                                 o_mem_addr, o_mem_we);
                    end else begin
                        b = exp_q[0];
                        if (o_mem_addr !== b.addr || o_mem_we !== b.we || (b.we && o_mem_wdata !== b.wdata)) begin
                            errors++;
                            $display("FAIL mem_beat: got addr %h we %b wdata %h, expected addr %h we %b wdata %h",
                                     o_mem_addr, o_mem_we, o_mem_wdata, b.addr, b.we, b.wdata);
                        end
                    end
                    ack = (ack_q.size() != 0) ? ack_q.pop_front() : 1'b1;
                    i_mem_ack   = ack;
                    i_mem_rdata = mem_word(o_mem_addr);
                    if (ack && exp_q.size() != 0) begin
                        resp_exp  = exp_q.pop_front();
                        resp_pend = 1'b1;
                    end
                end else begin
                    i_mem_ack   = idle_ack;
                    i_mem_rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge i_clk);
        checks++;
        if ({o_mem_req, o_mem_we, o_ic_valid, o_ic_done, o_dc_valid, o_dc_done} !== 6'b0 ||
            o_mem_addr !== '0 || o_mem_wdata !== '0 || o_ic_data !== '0 || o_dc_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got req %b we %b addr %h wdata %h icd %h dcd %h, expected all 0",
                     o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_ic_data, o_dc_data);
        end

        // Grant an IC refill, stall it, then reset in the middle of a cycle.
        set_acks(16'h0, 8);
        push_refill(1'b1, 32'h104);
        i_ic_addr = 32'h104;
        i_ic_req  = 1'b1;
        i_rst_n   = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        checks++;
        if (o_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req: got %b expected 1", o_mem_req);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_mem_we, o_ic_valid, o_ic_done, o_dc_valid, o_dc_done} !== 6'b0 ||
            o_mem_addr !== '0) begin
            errors++;
            $display("FAIL async_reset: got req %b addr %h flags %b, expected 0",
                     o_mem_req, o_mem_addr, {o_ic_valid, o_ic_done, o_dc_valid, o_dc_done});
        end
        flush();
        i_ic_req = 1'b0;

        // After reset last_grant is DC, so a tie goes to the IC first.
        @(negedge i_clk);
        push_refill(1'b1, 32'h104);
        push_refill(1'b0, 32'h208);
        i_ic_addr = 32'h104;
        i_dc_addr = 32'h208;
        i_dc_we   = 1'b0;
        i_ic_req  = 1'b1;
        i_dc_req  = 1'b1;
        i_rst_n   = 1'b1;
        wait_idle("first_contest", 60);
    endtask

    task automatic test_ic_refill();
        int grant_cyc;
        int base;
        @(negedge i_clk);
        base = ic_valid_cnt;
        push_refill(1'b1, 32'h104);
        i_ic_addr = 32'h104;
        i_ic_req  = 1'b1;
        grant_cyc = cyc + 1;
        wait_idle("ic_refill", 40);
        checks++;
        if (ic_valid_cnt - base != BL) begin
            errors++;
            $display("FAIL ic_valid_count: got %0d expected %0d", ic_valid_cnt - base, BL);
        end
        // Done is registered on edge grant+BL and sampled on the edge after.
        checks++;
        if (ic_done_cyc - grant_cyc != BL) begin
            errors++;
            $display("FAIL refill_latency: got %0d expected %0d", ic_done_cyc - grant_cyc, BL);
        end
    endtask

    task automatic test_contention();
        // The previous grant was IC, so the tie now goes to DC.
        @(negedge i_clk);
        push_refill(1'b0, 32'h200);
        push_refill(1'b1, 32'h1A8);
        i_ic_addr = 32'h1A8;
        i_dc_addr = 32'h200;
        i_dc_we   = 1'b0;
        i_ic_req  = 1'b1;
        i_dc_req  = 1'b1;
        wait_idle("contest_dc_first", 60);
        checks++;
        if (ic_done_cyc - dc_done_cyc != BL + 1) begin
            errors++;
            $display("FAIL contest_gap_dc_ic: got %0d expected %0d", ic_done_cyc - dc_done_cyc, BL + 1);
        end

        // A lone DC write moves last_grant to DC; the next tie goes to IC.
        @(negedge i_clk);
        push_write(32'h44, 32'h1234_5678);
        i_dc_addr  = 32'h44;
        i_dc_wdata = 32'h1234_5678;
        i_dc_we    = 1'b1;
        i_dc_req   = 1'b1;
        wait_idle("contest_write", 20);

        @(negedge i_clk);
        push_refill(1'b1, 32'h300);
        push_refill(1'b0, 32'h20C);
        i_ic_addr = 32'h300;
        i_dc_addr = 32'h20C;
        i_dc_we   = 1'b0;
        i_ic_req  = 1'b1;
        i_dc_req  = 1'b1;
        wait_idle("contest_ic_first", 60);
        checks++;
        if (dc_done_cyc - ic_done_cyc != BL + 1) begin
            errors++;
            $display("FAIL contest_gap_ic_dc: got %0d expected %0d", dc_done_cyc - ic_done_cyc, BL + 1);
        end
    endtask

    task automatic test_dc_write();
        int grant_cyc;
        @(negedge i_clk);
        set_acks(16'b0001, 4);
        push_write(32'h30, 32'hDEAD_BEEF);
        i_dc_addr  = 32'h30;
        i_dc_wdata = 32'hDEAD_BEEF;
        i_dc_we    = 1'b1;
        i_dc_req   = 1'b1;
        wait_idle("dc_write_delayed", 20);
        checks++;
        if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL write_release: got req %b we %b expected 0 0", o_mem_req, o_mem_we);
        end

        // Unaligned address is word-aligned; done one edge after grant.
        @(negedge i_clk);
        push_write(32'h36, 32'h0BAD_F00D);
        i_dc_addr  = 32'h36;
        i_dc_wdata = 32'h0BAD_F00D;
        i_dc_we    = 1'b1;
        i_dc_req   = 1'b1;
        grant_cyc  = cyc + 1;
        wait_idle("dc_write_fast", 20);
        checks++;
        if (dc_done_cyc - grant_cyc != 1) begin
            errors++;
            $display("FAIL write_latency: got %0d expected 1", dc_done_cyc - grant_cyc);
        end
    endtask

    task automatic test_stall();
        int base;
        @(negedge i_clk);
        base = ic_valid_cnt;
        set_acks(16'b1001101, 7);
        push_refill(1'b1, 32'h1F8);
        i_ic_addr = 32'h1F8;
        i_ic_req  = 1'b1;
        wait_idle("stall", 40);
        checks++;
        if (ic_valid_cnt - base != BL) begin
            errors++;
            $display("FAIL stall_valid_count: got %0d expected %0d", ic_valid_cnt - base, BL);
        end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        int n;
        @(negedge i_clk);
        base = ic_valid_cnt;
        set_acks(16'b1100000000, 10);
        push_refill(1'b1, 32'h104);
        i_ic_addr = 32'h104;
        i_ic_req  = 1'b1;
        n = 0;
        while (ic_valid_cnt - base < 2 && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (ic_valid_cnt - base < 2) begin
            errors++;
            $display("FAIL mid_burst_beats: got %0d valids expected 2", ic_valid_cnt - base);
        end
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_mem_we, o_ic_valid, o_ic_done, o_dc_valid, o_dc_done} !== 6'b0 ||
            o_mem_addr !== '0 || o_ic_data !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset: got req %b addr %h icd %h flags %b, expected 0",
                     o_mem_req, o_mem_addr, o_ic_data, {o_ic_valid, o_ic_done, o_dc_valid, o_dc_done});
        end
        // The IC request is still held and must restart from the line base.
        flush();
        push_refill(1'b1, 32'h104);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_idle("regrant", 40);
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        @(negedge i_clk);
        base    = ic_done_cnt;
        hold_ic = 1'b1;
        push_refill(1'b1, 32'h2C4);
        push_refill(1'b1, 32'h2C4);
        i_ic_addr = 32'h2C4;
        i_ic_req  = 1'b1;
        n = 0;
        while (ic_done_cnt == base && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        hold_ic = 1'b0;
        wait_idle("back_to_back", 40);
        checks++;
        if (ic_done_cnt - base != 2) begin
            errors++;
            $display("FAIL back_to_back_bursts: got %0d expected 2", ic_done_cnt - base);
        end
    endtask

    task automatic test_idle_ack();
        @(negedge i_clk);
        idle_ack = 1'b1;
        repeat (4) @(negedge i_clk);
        push_refill(1'b0, 32'h248);
        i_dc_addr = 32'h248;
        i_dc_we   = 1'b0;
        i_dc_req  = 1'b1;
        wait_idle("idle_ack", 40);
        idle_ack = 1'b0;
        checks++;
        if (o_dc_data !== mem_word(32'h24C)) begin
            errors++;
            $display("FAIL dc_last_word: got %h expected %h", o_dc_data, mem_word(32'h24C));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not end, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n     = 1'b1;
        i_ic_req    = 1'b0;
        i_ic_addr   = '0;
        i_dc_req    = 1'b0;
        i_dc_we     = 1'b0;
        i_dc_addr   = '0;
        i_dc_wdata  = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        #1;
        i_rst_n = 1'b0;

        test_reset();
        test_ic_refill();
        test_contention();
        test_dc_write();
        test_stall();
        test_reset_mid_burst();
        test_back_to_back();
        test_idle_ack();

        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
